// File: rtl/ready_request_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : ready_request_scheduler
// Purpose  : Central sequencer for the ready/request handshake between one
//            shared resource and N_REQ requesters. Issues one-cycle ready
//            pulses round-robin over the masked-in requesters, spaced by an
//            idle gap, and checks that the addressed requester answers with
//            request inside the allowed delay window.
// Ports    : clk        - clock, all logic on posedge
//            rst        - synchronous active-high reset
//            enable     - 0 pauses the gap counter and blocks new ready pulses
//            req_mask   - bit i=1 includes requester i in the rotation
//            err_clr    - clears err_sticky (a same-cycle set wins)
//            request    - request lines from the requesters
//            ready      - one-hot, one-cycle ready pulse
//            busy       - 1 while a handshake is in ISSUE or WAIT
//            cur_id     - requester being served or last served
//            done       - pulse: handshake completed inside the window
//            timeout    - pulse: no request inside the window
//            spurious   - pulse: request from a non-addressed requester
//            err_sticky - per-requester sticky error flags
// Revision : 1.0 - initial release
// ============================================================================
module ready_request_scheduler #(
    parameter int N_REQ    = 4,
    parameter int GAP_CYC  = 50,
    parameter int WAIT_MIN = 1,
    parameter int WAIT_MAX = 10
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       enable,
    input  logic [N_REQ-1:0]           req_mask,
    input  logic                       err_clr,
    input  logic [N_REQ-1:0]           request,
    output logic [N_REQ-1:0]           ready,
    output logic                       busy,
    output logic [$clog2(N_REQ)-1:0]   cur_id,
    output logic                       done,
    output logic                       timeout,
    output logic                       spurious,
    output logic [N_REQ-1:0]           err_sticky
);

    localparam int c_IDW = $clog2(N_REQ);
    localparam int c_GW  = $clog2(GAP_CYC + 1);
    localparam int c_KW  = $clog2(WAIT_MAX + 2);

    localparam logic [c_GW-1:0]  c_GAP_END = c_GW'(GAP_CYC);
    localparam logic [c_KW-1:0]  c_K_FIRST = c_KW'(WAIT_MIN + 1);
    localparam logic [c_KW-1:0]  c_K_LAST  = c_KW'(WAIT_MAX + 1);
    localparam logic [c_IDW-1:0] c_ID_LAST = c_IDW'(N_REQ - 1);

    typedef enum logic [1:0] {
        S_GAP   = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [c_GW-1:0]    r_gap_cnt;
    logic [c_KW-1:0]    r_k;
    logic [c_IDW-1:0]   r_ptr;
    logic [c_IDW-1:0]   r_cur_id;
    logic [N_REQ-1:0]   r_ready;
    logic               r_busy;
    logic               r_done;
    logic               r_timeout;
    logic               r_spurious;
    logic [N_REQ-1:0]   r_err;

    logic [c_IDW-1:0]   w_pick_id;
    logic               w_pick_vld;
    logic [N_REQ-1:0]   w_pick_oh;
    logic [N_REQ-1:0]   w_cur_oh;
    logic [N_REQ-1:0]   w_own;
    logic [N_REQ-1:0]   w_spur;
    logic               w_ok;
    logic               w_to;

    // First masked-in index at or after r_ptr, cyclically. The loop walks the
    // offsets from largest to smallest so the smallest offset wins.
    always_comb begin
        logic [c_IDW:0] v_idx;
        v_idx      = '0;
        w_pick_id  = r_ptr;
        w_pick_vld = 1'b0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            v_idx = {1'b0, r_ptr} + (c_IDW + 1)'(i);
            if (v_idx >= (c_IDW + 1)'(N_REQ)) begin
                v_idx = v_idx - (c_IDW + 1)'(N_REQ);
            end
            if (req_mask[v_idx[c_IDW-1:0]]) begin
                w_pick_id  = v_idx[c_IDW-1:0];
                w_pick_vld = 1'b1;
            end
        end
    end

    assign w_pick_oh = N_REQ'(1) << w_pick_id;
    assign w_cur_oh  = N_REQ'(1) << r_cur_id;

    // Only the addressed requester in WAIT owns its request line; any other
    // asserted request line is spurious.
    assign w_own  = (r_state == S_WAIT) ? w_cur_oh : '0;
    assign w_spur = request & ~w_own;

    // Early answers (k below the window) are silently ignored.
    assign w_ok = (r_state == S_WAIT) && request[r_cur_id] && (r_k >= c_K_FIRST);
    assign w_to = (r_state == S_WAIT) && !w_ok && (r_k == c_K_LAST);

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_GAP: begin
                if ((r_gap_cnt == c_GAP_END) && enable && w_pick_vld) begin
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (w_ok || w_to) begin
                    w_state_nxt = S_GAP;
                end
            end
            default: begin
                w_state_nxt = S_GAP;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_GAP;
            r_gap_cnt  <= '0;
            r_k        <= '0;
            r_ptr      <= '0;
            r_cur_id   <= '0;
            r_ready    <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_timeout  <= 1'b0;
            r_spurious <= 1'b0;
            r_err      <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_busy     <= (w_state_nxt != S_GAP);
            r_done     <= w_ok;
            r_timeout  <= w_to;
            r_spurious <= |w_spur;
            r_err      <= (r_err & ~{N_REQ{err_clr}}) | w_spur | (w_to ? w_cur_oh : '0);
            r_ready    <= '0;

            unique case (r_state)
                S_GAP: begin
                    if (w_state_nxt == S_ISSUE) begin
                        r_cur_id  <= w_pick_id;
                        r_ready   <= w_pick_oh;
                        r_gap_cnt <= '0;
                    end else if (enable && (r_gap_cnt != c_GAP_END)) begin
                        // Saturates at the terminal value while the mask is empty.
                        r_gap_cnt <= r_gap_cnt + c_GW'(1);
                    end
                end
                S_ISSUE: begin
                    r_ptr <= (r_cur_id == c_ID_LAST) ? '0 : r_cur_id + c_IDW'(1);
                    r_k   <= c_KW'(1);
                end
                S_WAIT: begin
                    if (w_state_nxt == S_WAIT) begin
                        r_k <= r_k + c_KW'(1);
                    end
                end
                default: begin
                    r_gap_cnt <= '0;
                end
            endcase
        end
    end

    assign ready      = r_ready;
    assign busy       = r_busy;
    assign cur_id     = r_cur_id;
    assign done       = r_done;
    assign timeout    = r_timeout;
    assign spurious   = r_spurious;
    assign err_sticky = r_err;

endmodule
`default_nettype wire

// File: tb/tb_ready_request_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_ready_request_scheduler
// Purpose  : Directed self-checking bench for ready_request_scheduler.
//            Expected values are derived from the cycle rules: the gap
//            counter counts 0..GAP_CYC in GAP, ready appears one cycle after
//            the terminal count, answers at k in WAIT_MIN+1..WAIT_MAX+1 give
//            done at k+1, otherwise timeout at WAIT_MAX+2.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ready_request_scheduler;

    localparam int N    = 4;
    localparam int GAP  = 50;
    localparam int WMIN = 1;
    localparam int WMAX = 10;

    logic         clk;
    logic         rst;
    logic         enable;
    logic [N-1:0] req_mask;
    logic         err_clr;
    logic [N-1:0] request;
    logic [N-1:0] ready;
    logic         busy;
    logic [1:0]   cur_id;
    logic         done;
    logic         timeout;
    logic         spurious;
    logic [N-1:0] err_sticky;

    int           total;
    int           bad;
    logic [N-1:0] exp_err;

    ready_request_scheduler #(
        .N_REQ    (N),
        .GAP_CYC  (GAP),
        .WAIT_MIN (WMIN),
        .WAIT_MAX (WMAX)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .req_mask   (req_mask),
        .err_clr    (err_clr),
        .request    (request),
        .ready      (ready),
        .busy       (busy),
        .cur_id     (cur_id),
        .done       (done),
        .timeout    (timeout),
        .spurious   (spurious),
        .err_sticky (err_sticky)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_cleared();
        check("rst_ready",    ready,      0);
        check("rst_busy",     busy,       0);
        check("rst_cur_id",   cur_id,     0);
        check("rst_done",     done,       0);
        check("rst_timeout",  timeout,    0);
        check("rst_spurious", spurious,   0);
        check("rst_err",      err_sticky, 0);
    endtask

    // Steps negedges until a ready pulse appears; exp_n is the number of
    // steps from the current negedge to the ready cycle.
    task automatic wait_ready(input int exp_id, input int exp_n);
        int n;
        n = 0;
        while (n < 400) begin
            @(negedge clk);
            n++;
            if (ready !== '0) break;
            check("gap_busy", busy, 0);
            check("gap_done_to", {done, timeout}, 0);
        end
        check("ready_delay", n, exp_n);
        check("ready_vec", ready, 32'd1 << exp_id);
        check("issue_cur_id", cur_id, exp_id);
        check("issue_busy", busy, 1);
    endtask

    // Called at the ready (cycle 0) negedge. Answers at delay k (0 = never),
    // optionally injects a request on sp_bit at cycle sp_c, optionally holds
    // enable low for the whole handshake. Ends one negedge after the
    // handshake-end cycle.
    task automatic handshake(input int id, input int k, input int sp_bit, input int sp_c,
                             input bit en_low);
        bit       expdone;
        int       endc;
        logic [N-1:0] rq;
        expdone = (k >= WMIN + 1) && (k <= WMAX + 1);
        endc    = expdone ? k + 1 : WMAX + 2;
        if (en_low) enable = 1'b0;
        for (int c = 1; c <= endc; c++) begin
            @(negedge clk);
            rq = '0;
            if (c == k) rq[id] = 1'b1;
            if (sp_c == c) rq[sp_bit] = 1'b1;
            request = rq;
            if (c == endc) enable = 1'b1;
            check("hs_done",    done,     expdone && (c == endc));
            check("hs_timeout", timeout,  !expdone && (c == endc));
            check("hs_spur",    spurious, (sp_c > 0) && (c == sp_c + 1));
            check("hs_busy",    busy,     c < endc);
            check("hs_ready",   ready,    0);
            check("hs_cur_id",  cur_id,   id);
        end
        if (!expdone) exp_err[id] = 1'b1;
        if (sp_c > 0) exp_err[sp_bit] = 1'b1;
        @(negedge clk);
        request = '0;
        // An answer landing in the timeout cycle is already back in GAP.
        check("hs_tail_spur", spurious, !expdone && (k == endc));
        check("hs_err", err_sticky, exp_err);
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        exp_err  = '0;
        rst      = 1'b1;
        enable   = 1'b1;
        req_mask = 4'b1111;
        err_clr  = 1'b0;
        request  = '0;

        // Reset state
        repeat (3) @(negedge clk);
        check_cleared();
        rst = 1'b0;

        // Baseline rotation 0,1,2,3,0 with answers at k=3
        wait_ready(0, GAP + 1);
        handshake(0, 3, 0, 0, 1'b0);
        for (int i = 1; i < 5; i++) begin
            wait_ready(i % N, GAP);
            handshake(i % N, 3, 0, 0, 1'b0);
        end

        // Window edges
        wait_ready(1, GAP);
        handshake(1, 2, 0, 0, 1'b0);
        wait_ready(2, GAP);
        handshake(2, 1, 0, 0, 1'b0);
        wait_ready(3, GAP);
        handshake(3, 11, 0, 0, 1'b0);
        wait_ready(0, GAP);
        handshake(0, 12, 0, 0, 1'b0);

        // enable low for 20 GAP cycles delays the next ready by exactly 20
        enable = 1'b0;
        repeat (20) begin
            @(negedge clk);
            check("en_low_ready", ready, 0);
        end
        enable = 1'b1;
        wait_ready(1, GAP);
        handshake(1, 4, 0, 0, 1'b1);

        // Mask 1010: only 1 and 3 are served
        req_mask = 4'b1010;
        wait_ready(3, GAP);
        handshake(3, 3, 0, 0, 1'b0);
        wait_ready(1, GAP);
        handshake(1, 3, 0, 0, 1'b0);
        wait_ready(3, GAP);
        handshake(3, 3, 0, 0, 1'b0);

        // Spurious request from 3 while waiting on 1
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        exp_err = '0;
        check("err_clr", err_sticky, 0);
        wait_ready(1, GAP - 1);
        handshake(1, 3, 3, 2, 1'b0);

        // Clear and new error on bit 3 in the same cycle: set wins
        err_clr = 1'b1;
        request = 4'b1000;
        @(negedge clk);
        err_clr = 1'b0;
        request = '0;
        check("clr_set_spur", spurious, 1);
        check("clr_set_err", err_sticky, 4'b1000);
        wait_ready(3, GAP - 1);
        handshake(3, 3, 0, 0, 1'b0);

        // Empty mask: no ready, then ready[2] the cycle after mask=0100
        req_mask = 4'b0000;
        repeat (60) begin
            @(negedge clk);
            check("mask0_ready", ready, 0);
            check("mask0_busy", busy, 0);
        end
        req_mask = 4'b0100;
        wait_ready(2, 1);
        handshake(2, 3, 0, 0, 1'b0);

        // Reset in WAIT at k=5
        req_mask = 4'b1111;
        wait_ready(3, GAP);
        repeat (5) @(negedge clk);
        check("wait_busy_k5", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_err = '0;
        check_cleared();
        wait_ready(0, GAP + 1);
        handshake(0, 3, 0, 0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
